// File: rtl/seq_mul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mul_ctrl
//  Purpose  : Sequencing controller for a multi-cycle shift-add unsigned
//             multiplier. It reuses one shared external WIDTH-bit adder,
//             applying one partial-product step per clock for WIDTH clocks,
//             then registers the 2*WIDTH-bit product and pulses done.
//  Ports    : clk       - rising-edge clock
//             rst_n     - asynchronous active-low reset
//             start     - multiply request (honoured in IDLE or DONE)
//             a, b      - multiplicand / multiplier, captured on acceptance
//             busy      - high while stepping (RUN)
//             done      - one-cycle completion pulse (DONE)
//             product   - last completed product, held until next completion
//             add_a     - adder operand A (accumulator high half)
//             add_b     - adder operand B (multiplicand gated by Q[0])
//             add_cin   - adder carry-in, tied low
//             add_s     - adder sum returned combinationally
//             add_cout  - adder carry-out returned combinationally
//  Revision : 1.0 - initial release
// ============================================================================
module seq_mul_ctrl #(
    parameter int WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_cin,
    input  logic [WIDTH-1:0]     add_s,
    input  logic                 add_cout
);

    localparam int            CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 busy_q, done_q;

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                // DONE accepts a new request directly so back-to-back
                // operations run without an idle bubble.
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // {ACC,Q} <= {cout, sum, Q} >> 1 : the carry-out becomes the
                // new accumulator MSB and the sum LSB moves into Q's MSB.
                acc_d = {add_cout, add_s[WIDTH-1:1]};
                q_d   = {add_s[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    prod_d  = {add_cout, add_s, q_q[WIDTH-1:1]};
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            // Status flags are flopped decodes of the next state so they
            // change only on the clock edge, free of decode glitches.
            busy_q  <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
        end
    end

    // ------------------------------------------------------------------
    // Outputs; the shared adder sees zeros outside RUN.
    // ------------------------------------------------------------------
    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;
    assign add_a   = (state_q == S_RUN) ? acc_q : '0;
    assign add_b   = ((state_q == S_RUN) && q_q[0]) ? m_q : '0;
    assign add_cin = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_mul_ctrl
//  Purpose  : Self-checking bench for seq_mul_ctrl with a behavioural adder
//             on the add_* ports and an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mul_ctrl;

    localparam int W = 5;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [W-1:0]     a, b;
    logic             busy, done;
    logic [2*W-1:0]   product;
    logic [W-1:0]     add_a, add_b, add_s;
    logic             add_cin, add_cout;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    seq_mul_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    // Behavioural shared adder
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: counts remaining steps; result is plain a*b.
    // ------------------------------------------------------------------
    int             m_cnt;
    int             m_a, m_b, m_pend;
    logic [2*W-1:0] m_prod;
    logic           m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_prod <= '0;
            m_done <= 1'b0;
            m_a    <= 0;
            m_b    <= 0;
            m_pend <= 0;
        end else if (m_cnt != 0) begin
            m_cnt  <= m_cnt - 1;
            m_done <= (m_cnt == 1);
            if (m_cnt == 1) m_prod <= m_pend[2*W-1:0];
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_cnt  <= W;
                m_a    <= int'(a);
                m_b    <= int'(b);
                m_pend <= int'(a) * int'(b);
            end
        end
    end

    // Per-cycle comparison. During step k the accumulator holds the partial
    // product a*(b mod 2^k) shifted down by k, and operand B is a when b[k]=1.
    always @(negedge clk) begin
        if (chk_en) begin
            int k;
            int exp_a, exp_b;
            k     = W - m_cnt;
            exp_a = 0;
            exp_b = 0;
            if (m_cnt != 0) begin
                exp_a = (m_a * (m_b & ((1 << k) - 1))) >> k;
                exp_b = ((m_b >> k) & 1) != 0 ? m_a : 0;
            end
            chk("busy",    32'(busy),    32'(m_cnt != 0));
            chk("done",    32'(done),    32'(m_done));
            chk("product", 32'(product), 32'(m_prod));
            chk("add_cin", 32'(add_cin), 32'd0);
            chk("add_a",   32'(add_a),   32'(exp_a));
            chk("add_b",   32'(add_b),   32'(exp_b));
        end
    end

    // Launch one operation, then track done/busy until done is seen.
    // Returns the negedge index (1 = first after the start edge) of done.
    task automatic run_op(input int av, input int bv, output int lat, output int nbusy);
        @(negedge clk);
        a     = W'(av);
        b     = W'(bv);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        nbusy = (busy === 1'b1) ? 1 : 0;
        for (int i = 2; i <= 20; i++) begin
            if (done === 1'b1) begin
                lat = i - 1;
                break;
            end
            @(negedge clk);
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    int lat, nb, ndone, nbusy_lo;

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Reset state
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_product", 32'(product), 32'd0);

        // Basic 21*13 with first-step adder drive
        @(negedge clk);
        a = 5'd21; b = 5'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("first_add_a", 32'(add_a), 32'd0);
        chk("first_add_b", 32'(add_b), 32'd21);
        nb = 1; lat = 0;
        for (int i = 2; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (busy === 1'b1) nb++;
            if (done === 1'b1) lat = i;
        end
        chk("lat_21x13",  32'(lat),     32'd6);
        chk("busy_21x13", 32'(nb),      32'd5);
        chk("prod_21x13", 32'(product), 32'd273);
        @(negedge clk);
        chk("done_once",  32'(done),    32'd0);

        // Extremes
        run_op(31, 31, lat, nb); chk("prod_31x31", 32'(product), 32'd961);
        run_op(0, 27, lat, nb);  chk("prod_0x27",  32'(product), 32'd0);
        run_op(31, 0, lat, nb);  chk("prod_31x0",  32'(product), 32'd0);

        // Back-to-back with start held high
        @(negedge clk);
        a = 5'd7; b = 5'd9; start = 1'b1;
        ndone = 0; nbusy_lo = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin a = 5'd30; b = 5'd17; end
            if (k == 7) start = 1'b0;
            if (busy !== 1'b1) nbusy_lo++;
            if (done === 1'b1) ndone++;
            if (k == 6)  chk("b2b_prod1", 32'(product), 32'd63);
            if (k == 6)  chk("b2b_done1", 32'(done),    32'd1);
            if (k == 12) chk("b2b_prod2", 32'(product), 32'd510);
            if (k == 12) chk("b2b_done2", 32'(done),    32'd1);
        end
        chk("b2b_ndone",   32'(ndone),    32'd2);
        chk("b2b_busy_lo", 32'(nbusy_lo), 32'd2);

        // Start while busy is dropped
        @(negedge clk);
        a = 5'd12; b = 5'd10; start = 1'b1;
        ndone = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 2) begin a = 5'd3; b = 5'd3; start = 1'b1; end
            if (done === 1'b1) ndone++;
            if (k == 6) chk("busy_prod", 32'(product), 32'd120);
        end
        chk("busy_ndone", 32'(ndone), 32'd1);
        chk("busy_idle",  32'(busy),  32'd0);

        // Asynchronous reset during RUN cycle 3
        @(negedge clk);
        a = 5'd9; b = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",    32'(busy),    32'd0);
        chk("arst_done",    32'(done),    32'd0);
        chk("arst_product", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("arst_idle", 32'(busy), 32'd0);
        run_op(5, 6, lat, nb); chk("prod_5x6", 32'(product), 32'd30);

        // Exhaustive sweep, checked cycle by cycle against the model
        for (int x = 0; x < (1 << W); x++) begin
            for (int y = 0; y < (1 << W); y++) begin
                run_op(x, y, lat, nb);
            end
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_mul_ctrl.md
Name: seq_mul_ctrl

Overview:
- Sequencing controller for a multi-cycle shift-add unsigned multiplier built around one shared external WIDTH-bit carry-select adder (fa5bit-class).
- Accepts a start pulse with two operands and drives the adder one partial-product step per cycle for WIDTH cycles.
- Registers the 2*WIDTH-bit product and flags completion.
- Sits beside the Dadda array as a low-area multiply path that reuses the adder hardware.

Parameters:
- WIDTH, 5, operand width in bits; legal range >= 2. The product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a multiply; sampled only when state is IDLE or DONE
- a  input  WIDTH  multiplicand, captured on start acceptance
- b  input  WIDTH  multiplier, captured on start acceptance
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, high while in DONE
- product  output  2*WIDTH  last completed product, registered
- add_a  output  WIDTH  adder operand A (accumulator high half)
- add_b  output  WIDTH  adder operand B (gated multiplicand)
- add_cin  output  1  adder carry-in, constant 0
- add_s  input  WIDTH  adder sum, combinational return from the adder
- add_cout  input  1  adder carry-out, combinational return from the adder

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE.
  - Internal registers M, ACC, Q and count are cleared.
  - busy=0, done=0, product=0.
  - Reset takes effect immediately, including mid-RUN. It aborts the operation and does not update product.
- States are IDLE, RUN, DONE. busy is decoded from state==RUN and done from state==DONE; both are glitch-free registered decodes.
- IDLE:
  - If start=1 at the clock edge: M<=a, Q<=b, ACC<=0, count<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, one step per clock:
  - Adder drive: add_a=ACC, add_b=(Q[0] ? M : 0), add_cin=0.
  - At the edge: {ACC,Q} <= {add_cout, add_s, Q} >> 1. This is a (2*WIDTH+1)-bit right shift; the LSB of Q is discarded.
  - count<=count+1.
  - When count==WIDTH-1 at the edge: product<={add_cout,add_s,Q}>>1 (low 2*WIDTH bits), go to DONE.
  - start is ignored while in RUN.
- DONE (exactly one cycle):
  - done=1.
  - If start=1: accept as in IDLE and go to RUN (back-to-back; no idle bubble).
  - Otherwise go to IDLE.
- Adder outputs in IDLE and DONE: add_a=0, add_b=0, add_cin=0. This keeps the shared adder quiet; the outputs are combinational from state and registers.
- Latency:
  - start sampled at edge E0.
  - Steps occur at edges E1..E_WIDTH.
  - product is updated and done rises at edge E_WIDTH.
  - done falls at E_WIDTH+1.
  - For WIDTH=5, done is high in the 6th cycle after the start edge. Throughput is one result per WIDTH+1 cycles.
- product:
  - Holds its value until the next completion or reset.
  - Not cleared on start.
  - Unchanged during RUN.
- Arithmetic:
  - Unsigned only.
  - The result must equal a*b exactly for all 2^(2*WIDTH) operand pairs.
  - Carry-out of each step is retained via the shift; no overflow is possible.
- Operands a and b may change freely after acceptance without affecting the result.

Test Plan:
- Basic multiply, WIDTH=5: reset, then start pulse with a=21, b=13.
  - First RUN cycle: add_a=0, add_b=21.
  - done pulses exactly once, 5 edges after the start edge; product=273; busy high for 5 cycles.
- Extremes:
  - a=31, b=31 -> product=961.
  - a=0, b=27 -> product=0, with add_b=0 on every RUN cycle.
  - a=31, b=0 -> product=0.
- Back-to-back: hold start=1 continuously with a=7, b=9, then change to a=30, b=17 after the first acceptance.
  - done pulses every 6 cycles.
  - products are 63, then 510; busy is low only during the DONE cycles.
- Start while busy: pulse start with a=3, b=3 during RUN cycle 2 of a 12*10 operation.
  - product=120 and only one done pulse occurs.
  - The second request is dropped.
- Reset mid-operation: assert rst_n=0 asynchronously (between clock edges) during RUN cycle 3.
  - busy, done and product go to 0 immediately; state is IDLE after release.
  - A subsequent 5*6 yields 30.
- Exhaustive: all 1024 pairs for WIDTH=5 against a reference model, using a behavioural adder (s=a+b+cin) on the add_* ports.
  - Zero mismatches.
  - Product is stable between done pulses.
